// File: rtl/lifo_rd_pkg.sv
// lifo_rd_pkg: shared types and constants for the lifo read-side drain engine
package lifo_rd_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} rd_state_t;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/lifo_rd_skid.sv
// lifo_rd_skid: 2-entry fall-through {data,last} FIFO; an arriving word shows at the head the same cycle when empty
module lifo_rd_skid
  import lifo_rd_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_en,
  output logic              valid,
  output logic [DWIDTH-1:0] data,
  output logic              last,
  output logic [1:0]        occ
);
  logic [DWIDTH:0] mem [BUF_DEPTH];
  logic wr_ptr, rd_ptr, push, pull;
  assign pull = rd_en && occ != 2'd0;
  // a word consumed on its arrival cycle never needs storing
  assign push = wr_en && !(occ == 2'd0 && rd_en);
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      occ <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pull;
      occ <= occ + {1'b0, push} - {1'b0, pull};
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {wr_last, wr_data};
  end
  assign valid = occ != 2'd0 || wr_en;
  assign {last, data} = occ != 2'd0 ? mem[rd_ptr] : wr_en ? {wr_last, wr_data} : '0;
endmodule

// File: rtl/lifo_rd_stream.sv
// lifo_rd_stream: drains a snapshot of lifo occupancy onto a valid/ready stream, top of stack first
module lifo_rd_stream
  import lifo_rd_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              start_i,
  output logic              rdreq_o,
  input  logic [DWIDTH-1:0] q_i,
  input  logic              empty_i,
  input  logic [AWIDTH:0]   usedw_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              underrun_o
);
  rd_state_t state;
  logic [AWIDTH:0] rem, rem_n;
  logic inflight, inflight_last, pop;
  logic [1:0] occ;
  logic [2:0] held;
  assign pop = valid_o && ready_i;
  assign held = {1'b0, occ} + {2'b0, inflight};
  // words buffered plus in flight may never exceed the buffer once this cycle's pop is counted
  assign rdreq_o = state == DRAIN && rem != '0 && !empty_i && held < 3'(BUF_DEPTH) + {2'b0, pop};
  assign rem_n = rem - {{AWIDTH{1'b0}}, rdreq_o};
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE;
      rem <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      inflight <= rdreq_o;
      inflight_last <= rdreq_o && rem_n == '0;
      rem <= rem_n;
      case (state)
        IDLE: if (start_i && !empty_i) begin
          rem <= usedw_i;
          underrun_o <= 1'b0;
          state <= DRAIN;
        end
        DRAIN: if (rem_n == '0) state <= FLUSH;
        else if (empty_i && !inflight) begin
          underrun_o <= 1'b1;
          state <= FLUSH;
        end
        FLUSH: if (held == {2'b0, pop}) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  lifo_rd_skid #(.DWIDTH(DWIDTH)) u_skid (
    .clk_i(clk_i),
    .arst_n_i(arst_n_i),
    .wr_en(inflight),
    .wr_data(q_i),
    .wr_last(inflight_last),
    .rd_en(pop),
    .valid(valid_o),
    .data(data_o),
    .last(last_o),
    .occ(occ)
  );
endmodule

// File: tb/tb_lifo_rd_stream.sv
// tb_lifo_rd_stream: drives the drain engine against a behavioural lifo with a scoreboard of expected words
module tb_lifo_rd_stream;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic arst_n_i, start_i, rdreq_o, empty_i, valid_o, last_o, ready_i, busy_o, underrun_o;
  logic [7:0] q_i, data_o;
  logic [4:0] usedw_i;
  int total = 0, bad = 0, n_rd = 0, n_x = 0, n_xfer = 0;
  logic [7:0] lmem [16];
  logic [4:0] lused = 5'd0;
  logic [7:0] lq = 8'd0, wdata = 8'd0;
  logic wrreq = 1'b0, ext_pop = 1'b0;
  logic [7:0] stk [$];
  logic [8:0] exp_q [$];
  logic [8:0] e;
  logic held_v = 1'b0;
  logic [7:0] held_d = 8'd0;
  assign q_i = lq;
  assign empty_i = lused == 5'd0;
  assign usedw_i = lused;

  lifo_rd_stream #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .start_i(start_i), .rdreq_o(rdreq_o),
    .q_i(q_i), .empty_i(empty_i), .usedw_i(usedw_i), .data_o(data_o),
    .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i), .busy_o(busy_o),
    .underrun_o(underrun_o)
  );

  // behavioural lifo: q is registered, valid the cycle after a pop
  always @(posedge clk_i) begin
    if (wrreq && lused < 5'd16) begin
      lmem[lused[3:0]] <= wdata;
      lused <= lused + 5'd1;
    end else if ((rdreq_o || ext_pop) && lused != 5'd0) begin
      if (rdreq_o) lq <= lmem[4'(lused - 5'd1)];
      lused <= lused - 5'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk_i) begin
    if (!arst_n_i) begin
      n_rd = 0;
      n_x = 0;
      held_v = 1'b0;
    end else begin
      if (rdreq_o) n_rd++;
      if (held_v) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, held_d);
      end
      if (valid_o && ready_i) begin
        n_x++;
        n_xfer++;
        if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("data", data_o, e[7:0]);
          chk("last", last_o, e[8]);
        end
        held_v = 1'b0;
      end else begin
        held_v = valid_o;
        held_d = data_o;
      end
      if (busy_o) chk("outstanding_le2", n_rd - n_x <= 2, 1);
    end
  end

  task automatic push(input logic [7:0] v);
    wrreq = 1'b1;
    wdata = v;
    @(posedge clk_i); #1;
    wrreq = 1'b0;
    stk.push_back(v);
  endtask

  // everything currently on the model stack is expected, newest first, last on the oldest
  task automatic expect_all();
    for (int i = stk.size() - 1; i >= 0; i--) exp_q.push_back({i == 0, stk[i]});
    stk.delete();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_i); #1;
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int x0;
    logic done;
    arst_n_i = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_outs", {rdreq_o, valid_o, data_o, last_o, busy_o, underrun_o}, 0);
    @(posedge clk_i); #1;
    arst_n_i = 1'b1;
    // three-word drain with exact cycle timing
    push(8'h11); push(8'h22); push(8'h33);
    ready_i = 1'b1;
    expect_all();
    pulse_start();
    @(negedge clk_i);
    chk("c1_busy_rdreq_valid", {busy_o, rdreq_o, valid_o}, 3'b110);
    @(negedge clk_i);
    chk("c2_rdreq_valid", {rdreq_o, valid_o}, 2'b11);
    @(negedge clk_i);
    chk("c3_rdreq_valid_last", {rdreq_o, valid_o, last_o}, 3'b110);
    @(negedge clk_i);
    chk("c4_rdreq_valid_last", {rdreq_o, valid_o, last_o}, 3'b011);
    @(negedge clk_i);
    chk("c5_busy_valid", {busy_o, valid_o}, 0);
    chk("t1_left", exp_q.size(), 0);
    @(posedge clk_i); #1;
    // full stack with a stalling consumer
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    expect_all();
    x0 = n_xfer;
    pulse_start();
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      ready_i = (k % 4 == 0) || (k % 4 == 3);
      @(posedge clk_i); #1;
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
    end
    ready_i = 1'b1;
    chk("t2_idle", done, 1);
    chk("t2_count", n_xfer - x0, 16);
    chk("t2_left", exp_q.size(), 0);
    // start with the lifo empty
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("t3_quiet", {rdreq_o, busy_o, valid_o}, 0);
    end
    @(posedge clk_i); #1;
    // reset in cycle 3 of a ten-word drain
    for (int i = 0; i < 10; i++) push(8'h80 + 8'(i));
    expect_all();
    pulse_start();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    arst_n_i = 1'b0;
    #1;
    chk("t4_rst_outs", {rdreq_o, valid_o, data_o, last_o, busy_o, underrun_o}, 0);
    exp_q.delete();
    @(posedge clk_i); #1;
    arst_n_i = 1'b1;
    chk("t4_left_in_lifo", lused, 8);
    for (int i = 0; i < 10; i++) stk.push_back(8'h80 + 8'(i));
    while (stk.size() > 8) void'(stk.pop_back());
    expect_all();
    pulse_start();
    wait_idle("t4_idle");
    chk("t4_left", exp_q.size(), 0);
    // start pulses while busy are ignored
    for (int i = 0; i < 5; i++) push(8'hc0 + 8'(i));
    expect_all();
    x0 = n_xfer;
    pulse_start();
    @(posedge clk_i); #1;
    pulse_start();
    wait_idle("t5_idle");
    chk("t5_count", n_xfer - x0, 5);
    chk("t5_left", exp_q.size(), 0);
    chk("t5_lifo_empty", lused, 0);
    // external pops empty the lifo while the consumer stalls
    for (int i = 1; i <= 5; i++) push(8'ha0 + 8'(i));
    stk.delete();
    exp_q.push_back({1'b0, 8'ha5});
    exp_q.push_back({1'b0, 8'ha4});
    ready_i = 1'b0;
    pulse_start();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    ext_pop = 1'b1;
    repeat (3) begin @(posedge clk_i); #1; end
    ext_pop = 1'b0;
    @(posedge clk_i); #1;
    chk("t6_underrun_set", underrun_o, 1);
    ready_i = 1'b1;
    wait_idle("t6_idle");
    chk("t6_underrun_sticky", underrun_o, 1);
    chk("t6_left", exp_q.size(), 0);
    push(8'h5a);
    expect_all();
    pulse_start();
    chk("t6_underrun_cleared", underrun_o, 0);
    wait_idle("t6b_idle");
    chk("t6b_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
